// File: rtl/lc3b_control_ext.sv
// lc3b_control_ext: multicycle Moore control unit for the LC-3b datapath.
// Adds LEA, JMP, a bounded memory-wait timeout and illegal-opcode reporting.
// Optional byte loads/stores are compiled in when LC3B_BYTE_OPS_EN is defined.
`timescale 1ns/1ps

package lc3b_ext_pkg;
    typedef enum logic [3:0] {
        op_br   = 4'd0,  op_add = 4'd1,  op_ldb = 4'd2,  op_stb  = 4'd3,
        op_jsr  = 4'd4,  op_and = 4'd5,  op_ldr = 4'd6,  op_str  = 4'd7,
        op_rti  = 4'd8,  op_not = 4'd9,  op_ldi = 4'd10, op_sti  = 4'd11,
        op_jmp  = 4'd12, op_shf = 4'd13, op_lea = 4'd14, op_trap = 4'd15
    } lc3b_opcode;

    typedef enum logic [2:0] {
        alu_add, alu_and, alu_not, alu_pass, alu_sll, alu_srl, alu_sra
    } lc3b_aluop;
endpackage

module lc3b_control_ext #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  lc3b_ext_pkg::lc3b_opcode opcode,
    input  logic                     branch_enable,
    input  logic                     mem_resp,
    input  logic                     mar_lsb,
    output logic                     load_pc,
    output logic                     load_ir,
    output logic                     load_regfile,
    output logic                     load_mar,
    output logic                     load_mdr,
    output logic                     load_cc,
    output logic [1:0]               pcmux_sel,
    output logic [1:0]               alumux_sel,
    output logic [1:0]               regfilemux_sel,
    output logic                     marmux_sel,
    output logic                     mdrmux_sel,
    output logic                     storemux_sel,
    output lc3b_ext_pkg::lc3b_aluop  aluop,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [1:0]               mem_byte_enable,
    output logic                     illegal_op,
    output logic                     mem_timeout
);
    import lc3b_ext_pkg::*;

    localparam int CLOG = $clog2(MEM_TIMEOUT + 1);
    localparam int CW   = (CLOG < 1) ? 1 : CLOG;
    localparam int LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] CNT_LAST = CW'(LAST);

    typedef enum logic [4:0] {
        S_IDLE, S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
        S_ADD, S_AND, S_NOT, S_BR, S_BR_TAKEN, S_JMP, S_LEA,
        S_CALC_ADDR, S_LDR1, S_LDR2, S_STR1, S_STR2,
        S_LDB1, S_LDB2, S_STB1, S_STB2, S_ERR
    } state_t;

    state_t        state, next;
    logic [CW-1:0] cnt;
    logic          is_wait;
    logic          timeout_hit;

`ifndef LC3B_BYTE_OPS_EN
    // Byte lane select only matters for byte stores.
    logic unused_mar_lsb;
    assign unused_mar_lsb = mar_lsb;
`endif

    assign is_wait = (state == S_FETCH2) || (state == S_LDR1) || (state == S_LDB1) ||
                     (state == S_STR2)   || (state == S_STB2);

    // Last permitted wait cycle with no response: give up on this access.
    assign timeout_hit = (MEM_TIMEOUT != 0) && is_wait && !mem_resp && (cnt == CNT_LAST);

    // State register; async reset drops every strobe immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next;
    end

    // Wait counter: counts cycles spent stalled in the current wait state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        cnt <= '0;
        else if (is_wait && next == state) cnt <= cnt + 1'b1;
        else                               cnt <= '0;
    end

    // Next-state and Moore outputs (illegal_op also looks at the opcode in DECODE).
    always_comb begin
        next            = state;
        load_pc         = 1'b0;
        load_ir         = 1'b0;
        load_regfile    = 1'b0;
        load_mar        = 1'b0;
        load_mdr        = 1'b0;
        load_cc         = 1'b0;
        pcmux_sel       = 2'd0;
        alumux_sel      = 2'd0;
        regfilemux_sel  = 2'd0;
        marmux_sel      = 1'b0;
        mdrmux_sel      = 1'b0;
        storemux_sel    = 1'b0;
        aluop           = alu_add;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = 2'b11;
        illegal_op      = 1'b0;
        mem_timeout     = 1'b0;

        case (state)
            S_IDLE: begin
                mem_byte_enable = 2'b00;
                next            = S_FETCH1;
            end
            S_FETCH1: begin
                marmux_sel = 1'b1;
                load_mar   = 1'b1;
                load_pc    = 1'b1;
                next       = S_FETCH2;
            end
            S_FETCH2: begin
                mem_read   = 1'b1;
                mdrmux_sel = 1'b1;
                load_mdr   = 1'b1;
                next       = S_FETCH3;
            end
            S_FETCH3: begin
                load_ir = 1'b1;
                next    = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    op_add:         next = S_ADD;
                    op_and:         next = S_AND;
                    op_not:         next = S_NOT;
                    op_br:          next = S_BR;
                    op_jmp:         next = S_JMP;
                    op_lea:         next = S_LEA;
                    op_ldr, op_str: next = S_CALC_ADDR;
`ifdef LC3B_BYTE_OPS_EN
                    op_ldb, op_stb: next = S_CALC_ADDR;
`endif
                    default: begin
                        illegal_op = 1'b1;
                        next       = S_FETCH1;
                    end
                endcase
            end
            S_ADD, S_AND, S_NOT: begin
                aluop        = (state == S_ADD) ? alu_add :
                               (state == S_AND) ? alu_and : alu_not;
                load_regfile = 1'b1;
                load_cc      = 1'b1;
                next         = S_FETCH1;
            end
            S_BR: next = branch_enable ? S_BR_TAKEN : S_FETCH1;
            S_BR_TAKEN: begin
                pcmux_sel = 2'd1;
                load_pc   = 1'b1;
                next      = S_FETCH1;
            end
            S_JMP: begin
                pcmux_sel = 2'd2;
                load_pc   = 1'b1;
                next      = S_FETCH1;
            end
            S_LEA: begin
                regfilemux_sel = 2'd2;
                load_regfile   = 1'b1;
                load_cc        = 1'b1;
                next           = S_FETCH1;
            end
            S_CALC_ADDR: begin
                load_mar = 1'b1;
                case (opcode)
                    op_ldr: begin alumux_sel = 2'd1; next = S_LDR1; end
                    op_str: begin alumux_sel = 2'd1; next = S_STR1; end
`ifdef LC3B_BYTE_OPS_EN
                    op_ldb: begin alumux_sel = 2'd2; next = S_LDB1; end
                    op_stb: begin alumux_sel = 2'd2; next = S_STB1; end
`endif
                    default: next = S_FETCH1;
                endcase
            end
            S_LDR1: begin
                mem_read   = 1'b1;
                mdrmux_sel = 1'b1;
                load_mdr   = 1'b1;
                next       = S_LDR2;
            end
            S_LDR2: begin
                regfilemux_sel = 2'd1;
                load_regfile   = 1'b1;
                load_cc        = 1'b1;
                next           = S_FETCH1;
            end
            S_STR1: begin
                storemux_sel = 1'b1;
                aluop        = alu_pass;
                load_mdr     = 1'b1;
                next         = S_STR2;
            end
            S_STR2: begin
                mem_write = 1'b1;
                next      = S_FETCH1;
            end
`ifdef LC3B_BYTE_OPS_EN
            S_LDB1: begin
                mem_read   = 1'b1;
                mdrmux_sel = 1'b1;
                load_mdr   = 1'b1;
                next       = S_LDB2;
            end
            S_LDB2: begin
                regfilemux_sel = 2'd3;
                load_regfile   = 1'b1;
                load_cc        = 1'b1;
                next           = S_FETCH1;
            end
            S_STB1: begin
                storemux_sel = 1'b1;
                aluop        = alu_pass;
                load_mdr     = 1'b1;
                next         = S_STB2;
            end
            S_STB2: begin
                mem_write       = 1'b1;
                mem_byte_enable = mar_lsb ? 2'b10 : 2'b01;
                next            = S_FETCH1;
            end
`endif
            S_ERR: begin
                mem_byte_enable = 2'b00;
                mem_timeout     = 1'b1;
                next            = S_ERR;
            end
            default: next = S_IDLE;
        endcase

        // Stall in a wait state until memory answers; a response on the
        // final allowed cycle still completes the access.
        if (is_wait && !mem_resp)
            next = timeout_hit ? S_ERR : state;
    end
endmodule

// File: tb/tb_lc3b_control_ext.sv
// Scoreboard bench for lc3b_control_ext: an instruction-level model queues the
// expected control word of every cycle; a negedge monitor pops and compares.
`timescale 1ns/1ps

module tb_lc3b_control_ext;
    import lc3b_ext_pkg::*;

    typedef struct packed {
        logic       load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc;
        logic [1:0] pcmux_sel, alumux_sel, regfilemux_sel;
        logic       marmux_sel, mdrmux_sel, storemux_sel;
        lc3b_aluop  aluop;
        logic       mem_read, mem_write;
        logic [1:0] mem_byte_enable;
        logic       illegal_op, mem_timeout;
    } ctl_t;

    typedef struct { ctl_t c; string name; } exp_t;
    typedef struct { logic [31:0] act; logic [31:0] exp; string name; } dchk_t;

    logic clk = 1'b0, rst_n = 1'b0;
    lc3b_opcode opcode = op_br;
    logic branch_enable = 1'b0, mem_resp = 1'b0, mar_lsb = 1'b0;
    logic load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc;
    logic [1:0] pcmux_sel, alumux_sel, regfilemux_sel, mem_byte_enable;
    logic marmux_sel, mdrmux_sel, storemux_sel, mem_read, mem_write, illegal_op, mem_timeout;
    lc3b_aluop aluop;
    ctl_t act;

    exp_t  sbq[$];
    dchk_t dq[$];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    lc3b_control_ext #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_enable(branch_enable),
        .mem_resp(mem_resp), .mar_lsb(mar_lsb), .load_pc(load_pc), .load_ir(load_ir),
        .load_regfile(load_regfile), .load_mar(load_mar), .load_mdr(load_mdr),
        .load_cc(load_cc), .pcmux_sel(pcmux_sel), .alumux_sel(alumux_sel),
        .regfilemux_sel(regfilemux_sel), .marmux_sel(marmux_sel), .mdrmux_sel(mdrmux_sel),
        .storemux_sel(storemux_sel), .aluop(aluop), .mem_read(mem_read),
        .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
        .illegal_op(illegal_op), .mem_timeout(mem_timeout)
    );

    assign act = ctl_t'({load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc,
                         pcmux_sel, alumux_sel, regfilemux_sel, marmux_sel, mdrmux_sel,
                         storemux_sel, aluop, mem_read, mem_write, mem_byte_enable,
                         illegal_op, mem_timeout});

    // Monitor: compares every queued expectation at the falling edge of its cycle.
    exp_t  em;
    dchk_t dm;
    always @(negedge clk) begin
        while (dq.size() > 0) begin
            dm = dq.pop_front();
            checks++;
            if (dm.act !== dm.exp) begin
                errors++;
                $display("FAIL %s got %0h expected %0h", dm.name, dm.act, dm.exp);
            end
        end
        if (sbq.size() > 0) begin
            em = sbq.pop_front();
            checks++;
            if (act !== em.c) begin
                errors++;
                $display("FAIL %s @%0t got %h expected %h", em.name, $time, act, em.c);
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic ctl_t base();
        ctl_t c = '0;
        c.mem_byte_enable = 2'b11;
        return c;
    endfunction

    function automatic logic illegal(lc3b_opcode op);
        case (op)
            op_add, op_and, op_not, op_br, op_jmp, op_lea, op_ldr, op_str: return 1'b0;
`ifdef LC3B_BYTE_OPS_EN
            op_ldb, op_stb: return 1'b0;
`endif
            default: return 1'b1;
        endcase
    endfunction

    function automatic ctl_t w_f1();
        ctl_t c = base();
        c.marmux_sel = 1'b1; c.load_mar = 1'b1; c.load_pc = 1'b1;
        return c;
    endfunction

    function automatic ctl_t w_memrd();
        ctl_t c = base();
        c.mem_read = 1'b1; c.mdrmux_sel = 1'b1; c.load_mdr = 1'b1;
        return c;
    endfunction

    function automatic ctl_t w_calc(logic [1:0] am);
        ctl_t c = base();
        c.alumux_sel = am; c.load_mar = 1'b1;
        return c;
    endfunction

    // Present this cycle's inputs, queue its expected outputs, move to next cycle.
    task automatic emit(input ctl_t c, input logic resp, input string nm);
        mem_resp = resp;
        sbq.push_back('{c, nm});
        @(posedge clk); #1;
    endtask

    // A memory access that stalls w cycles and then completes.
    task automatic memwait(input ctl_t c, input int w, input string nm);
        for (int i = 0; i < w; i++) emit(c, 1'b0, nm);
        emit(c, 1'b1, nm);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        emit('0, rb(), "reset_hold");
        emit('0, rb(), "reset_hold");
        rst_n = 1'b1;
        emit('0, rb(), "idle");
    endtask

    task automatic fetch(input lc3b_opcode op, input int w1);
        ctl_t c;
        emit(w_f1(), rb(), "fetch1");
        memwait(w_memrd(), w1, "fetch2");
        c = base(); c.load_ir = 1'b1;
        emit(c, rb(), "fetch3");
        c = base(); c.illegal_op = illegal(op);
        emit(c, rb(), "decode");
    endtask

    task automatic instr(input lc3b_opcode op, input logic be, input logic lsb,
                         input int w1, input int w2);
        ctl_t c;
        opcode = op; branch_enable = be; mar_lsb = lsb;
        fetch(op, w1);
        if (illegal(op)) return;
        case (op)
            op_add, op_and, op_not: begin
                c = base();
                c.aluop = (op == op_add) ? alu_add : (op == op_and) ? alu_and : alu_not;
                c.load_regfile = 1'b1; c.load_cc = 1'b1;
                emit(c, rb(), "alu_exec");
            end
            op_br: begin
                emit(base(), rb(), "br");
                if (be) begin
                    c = base(); c.pcmux_sel = 2'd1; c.load_pc = 1'b1;
                    emit(c, rb(), "br_taken");
                end
            end
            op_jmp: begin
                c = base(); c.pcmux_sel = 2'd2; c.load_pc = 1'b1;
                emit(c, rb(), "jmp");
            end
            op_lea: begin
                c = base(); c.regfilemux_sel = 2'd2; c.load_regfile = 1'b1; c.load_cc = 1'b1;
                emit(c, rb(), "lea");
            end
            op_ldr, op_ldb: begin
                emit(w_calc((op == op_ldr) ? 2'd1 : 2'd2), rb(), "calc_addr");
                memwait(w_memrd(), w2, "load1");
                c = base(); c.load_regfile = 1'b1; c.load_cc = 1'b1;
                c.regfilemux_sel = (op == op_ldr) ? 2'd1 : 2'd3;
                emit(c, rb(), "load2");
            end
            default: begin // op_str, op_stb
                emit(w_calc((op == op_str) ? 2'd1 : 2'd2), rb(), "calc_addr");
                c = base(); c.storemux_sel = 1'b1; c.aluop = alu_pass; c.load_mdr = 1'b1;
                emit(c, rb(), "store1");
                c = base(); c.mem_write = 1'b1;
                if (op == op_stb) c.mem_byte_enable = lsb ? 2'b10 : 2'b01;
                memwait(c, w2, "store2");
            end
        endcase
    endtask

    // ---------------- stimulus ----------------
    initial begin
        ctl_t c;
        @(posedge clk); #1;
        do_reset();

        instr(op_add, 1'b0, 1'b0, 0, 0);
        instr(op_br,  1'b0, 1'b0, 0, 0);
        instr(op_br,  1'b1, 1'b0, 0, 0);
        instr(op_trap, 1'b0, 1'b0, 0, 0);
        instr(op_ldr, 1'b0, 1'b1, 1, 3);
        instr(op_str, 1'b1, 1'b0, 0, 2);
        instr(op_jmp, 1'b0, 1'b0, 2, 0);
        instr(op_lea, 1'b0, 1'b0, 0, 0);
        instr(op_ldb, 1'b0, 1'b1, 0, 1);
        instr(op_stb, 1'b0, 1'b1, 0, 2);
        instr(op_stb, 1'b0, 1'b0, 0, 0);
        // Response arrives on the 4th (last allowed) FETCH2 cycle.
        instr(op_not, 1'b0, 1'b0, 3, 0);

        // Memory never answers in FETCH2: 4 stall cycles, then sticky error.
        opcode = op_add;
        emit(w_f1(), rb(), "to_fetch1");
        for (int i = 0; i < 4; i++) emit(w_memrd(), 1'b0, "to_fetch2");
        c = '0; c.mem_timeout = 1'b1;
        for (int i = 0; i < 3; i++) emit(c, rb(), "err_hold");
        #1 rst_n = 1'b0;
        #1 dq.push_back('{32'(mem_timeout), 32'd0, "err_async_clear"});
        @(posedge clk); #1;
        do_reset();

        // Reset pulsed during a load's memory read.
        opcode = op_ldr;
        fetch(op_ldr, 0);
        emit(w_calc(2'd1), rb(), "calc_addr");
        mem_resp = 1'b0;
        dq.push_back('{32'(mem_read), 32'd1, "ldr1_read"});
        #2 rst_n = 1'b0;
        #1 dq.push_back('{32'(mem_read), 32'd0, "ldr1_reset_drop"});
        dq.push_back('{32'(mem_timeout), 32'd0, "ldr1_reset_timeout"});
        @(posedge clk); #1;
        do_reset();

        for (int n = 0; n < 250; n++)
            instr(lc3b_opcode'(4'($urandom_range(0, 15))), rb(), rb(),
                  $urandom_range(0, 3), $urandom_range(0, 3));

        @(negedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end
endmodule
